mouse_packet_decoder: RTL and testbench
=======================================

// Module: mouse_packet_decoder
// PURPOSE
//  Decodes the 3-byte PS/2 mouse stream into absolute, clamped screen coordinates and button state.
//  Sits between the PS/2 byte receiver and the position register stage.
//  Drives xpos/ypos/mouseleft for the drawing pipeline.
// PARAMETERS
//  XMAX           800      screen width; xpos range 0..XMAX-1
//  YMAX           600      screen height; ypos range 0..YMAX-1
//  XINIT          400      xpos after reset
//  YINIT          300      ypos after reset
//  TIMEOUT_CYC    4000000  max clk cycles between bytes of one packet (timeout build only)
// PORTS
//  clk             in   1   system clock, all logic on rising edge
//  rst             in   1   asynchronous, active-low reset
//  rx_data         in   8   byte from PS/2 receiver
//  rx_valid        in   1   one-cycle strobe, rx_data valid
//  xpos_out        out  12  absolute x position
//  ypos_out        out  12  absolute y position, 0 = top
//  mouseleft_out   out  1   left button, 1 = pressed
//  mouseright_out  out  1   right button, 1 = pressed
//  pos_valid       out  1   one-cycle pulse; outputs updated this cycle
//  sync_err        out  1   one-cycle pulse; byte discarded for bad sync
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=WAIT_B0; xpos_out=XINIT; ypos_out=YINIT; buttons=0; pos_valid=0; sync_err=0.
//  - FSM: WAIT_B0 -> WAIT_B1 -> WAIT_B2 -> UPDATE -> WAIT_B0. Each of the first three states advances only on rx_valid.
//  - WAIT_B0: accept the byte only if bit3==1 (status byte); store it and go to WAIT_B1.
//    If bit3==0: discard, pulse sync_err, stay in WAIT_B0.
//  - WAIT_B1 stores dx[7:0]. WAIT_B2 stores dy[7:0].
//  - UPDATE lasts one cycle. All outputs change and pos_valid=1 in the cycle after the third byte is accepted.
//  - rx_valid during UPDATE: the byte is processed as if in WAIT_B0 (sync check applies). No byte is lost.
//  - Delta: dx = signed{b0[4],b1} (9 bit); dy = signed{b0[5],b2}.
//    X overflow (b0[6]) forces dx=0. Y overflow (b0[7]) forces dy=0.
//  - Arithmetic: 14-bit signed. nx = x+dx; ny = y-dy (PS/2 +y = up).
//    Clamp each to [0, MAX-1] before register load. No wrap-around.
//  - Buttons: mouseleft_out=b0[0], mouseright_out=b0[1]. Updated in UPDATE even when deltas are 0 or overflowed.
//  - Outputs hold between UPDATEs. pos_valid and sync_err are low except for their single-cycle pulses.
//  - Reset asserted mid-packet: the partial packet is dropped and position returns to XINIT/YINIT.
// CONFIGURATION
//  MOUSE_PKT_TIMEOUT_EN
//   defined: a counter runs in WAIT_B1/WAIT_B2 and clears on each accepted byte.
//     On reaching TIMEOUT_CYC, return to WAIT_B0, drop the partial packet, pulse sync_err.
//     A byte arriving in the same cycle as the timeout is evaluated as a WAIT_B0 byte.
//   undefined: no counter. The FSM waits indefinitely for bytes 2 and 3. TIMEOUT_CYC is unused.
// STRUCTURE
//  - Shared package mouse_pkg:
//    - FSM state encoding (WAIT_B0, WAIT_B1, WAIT_B2, UPDATE);
//    - status-bit index constants (BTN_L=0, BTN_R=1, SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7);
//    - position width constant POS_W=12.
//  - Sub-module mouse_axis_clamp (param MAX): 12-bit position + 9-bit signed delta + subtract flag
//    -> clamped 12-bit result. Instantiated once per axis.
// TESTING
//  1 Reset, then packet 08,05,03 -> one cycle after byte 3: x=405, y=297, L=0, R=0, pos_valid pulses once.
//  2 Packet 19,FB,00 (dx=-5, left pressed) -> x=395, y=300, mouseleft_out=1.
//  3 Clamp: x=797, packet 08,0A,00 -> x=799; y=2, packet 08,00,05 -> y=0 (no wrap).
//  4 Overflow: packet 48,FF,02 -> x unchanged, y=298.
//  5 Sync: byte 05 in WAIT_B0 -> sync_err pulse, no pos_valid; then 08,01,00 decodes normally (x+1).
//  6 Timeout (macro on, TIMEOUT_CYC=100): 08,03, then idle 100 cycles -> sync_err pulse.
//    Then 08,01,00 -> x+1 only. Also: rst low mid-packet -> x=400, y=300 immediately.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder: FSM encoding,
// status-byte bit positions and the position width.
package mouse_pkg;

  localparam int POS_W = 12;

  localparam logic [1:0] WAIT_B0 = 2'd0;
  localparam logic [1:0] WAIT_B1 = 2'd1;
  localparam logic [1:0] WAIT_B2 = 2'd2;
  localparam logic [1:0] UPDATE  = 2'd3;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

endpackage

// File: rtl/mouse_axis_clamp.sv
// One axis of the position update: pos +/- delta in 14-bit signed
// arithmetic, saturated to [0, MAX-1].
module mouse_axis_clamp
  import mouse_pkg::*;
#(
  parameter int MAX = 800
) (
  input  logic [POS_W-1:0] pos,
  input  logic signed [8:0] delta,
  input  logic              sub,
  output logic [POS_W-1:0] result
);

  localparam logic signed [13:0] LIMIT = 14'(MAX - 1);

  logic signed [13:0] pos_ext;
  logic signed [13:0] delta_ext;
  logic signed [13:0] sum;

  assign pos_ext   = signed'({2'b00, pos});
  assign delta_ext = signed'({{5{delta[8]}}, delta});
  assign sum       = sub ? (pos_ext - delta_ext) : (pos_ext + delta_ext);

  always_comb begin
    result = sum[POS_W-1:0];
    if (sum < 14'sd0) begin
      result = '0;
    end else if (sum > LIMIT) begin
      result = LIMIT[POS_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Decodes the 3-byte PS/2 mouse stream into clamped absolute coordinates
// and button state. Define MOUSE_PKT_TIMEOUT_EN for the inter-byte timeout.
module mouse_packet_decoder
  import mouse_pkg::*;
#(
  parameter int XMAX        = 800,
  parameter int YMAX        = 600,
  parameter int XINIT       = 400,
  parameter int YINIT       = 300,
  parameter int TIMEOUT_CYC = 4000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [POS_W-1:0] xpos_out,
  output logic [POS_W-1:0] ypos_out,
  output logic             mouseleft_out,
  output logic             mouseright_out,
  output logic             pos_valid,
  output logic             sync_err
);

  logic [1:0]       state_reg, state_next;
  logic [7:4]       b0_hi_reg;
  logic [1:0]       b0_btn_reg;
  logic [7:0]       b1_reg;
  logic [POS_W-1:0] x_reg, y_reg;
  logic             left_reg, right_reg;
  logic             pos_valid_reg, sync_err_reg;
  logic             sync_err_next;
  logic             load_b0, load_b1, load_pos;
  logic             timeout;
  logic signed [8:0] dx, dy;
  logic [POS_W-1:0] x_next, y_next;

`ifdef MOUSE_PKT_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_reg;
  logic             in_packet;

  assign in_packet = (state_reg == WAIT_B1) || (state_reg == WAIT_B2);
  assign timeout   = in_packet && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  // Idle cycles since the last accepted byte of the current packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (!in_packet || rx_valid || timeout) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // A timed-out packet makes the current byte a fresh status-byte candidate.
  always_comb begin
    state_next    = state_reg;
    sync_err_next = timeout;
    load_b0       = 1'b0;
    load_b1       = 1'b0;
    load_pos      = 1'b0;
    if (state_reg == WAIT_B0 || state_reg == UPDATE || timeout) begin
      state_next = WAIT_B0;
      if (rx_valid) begin
        if (rx_data[SYNC]) begin
          load_b0    = 1'b1;
          state_next = WAIT_B1;
        end else begin
          sync_err_next = 1'b1;
        end
      end
    end else if (rx_valid) begin
      if (state_reg == WAIT_B1) begin
        load_b1    = 1'b1;
        state_next = WAIT_B2;
      end else begin
        load_pos   = 1'b1;
        state_next = UPDATE;
      end
    end
  end

  // dy comes straight from the third byte so outputs are valid in UPDATE.
  assign dx = b0_hi_reg[XOVF] ? 9'sd0 : signed'({b0_hi_reg[XSIGN], b1_reg});
  assign dy = b0_hi_reg[YOVF] ? 9'sd0 : signed'({b0_hi_reg[YSIGN], rx_data});

  mouse_axis_clamp #(.MAX(XMAX)) u_clamp_x (
    .pos    (x_reg),
    .delta  (dx),
    .sub    (1'b0),
    .result (x_next)
  );

  mouse_axis_clamp #(.MAX(YMAX)) u_clamp_y (
    .pos    (y_reg),
    .delta  (dy),
    .sub    (1'b1),
    .result (y_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= WAIT_B0;
      b0_hi_reg     <= '0;
      b0_btn_reg    <= '0;
      b1_reg        <= '0;
      x_reg         <= POS_W'(XINIT);
      y_reg         <= POS_W'(YINIT);
      left_reg      <= 1'b0;
      right_reg     <= 1'b0;
      pos_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pos_valid_reg <= load_pos;
      sync_err_reg  <= sync_err_next;
      if (load_b0) begin
        b0_hi_reg  <= rx_data[7:4];
        b0_btn_reg <= rx_data[1:0];
      end
      if (load_b1) begin
        b1_reg <= rx_data;
      end
      if (load_pos) begin
        x_reg     <= x_next;
        y_reg     <= y_next;
        left_reg  <= b0_btn_reg[BTN_L];
        right_reg <= b0_btn_reg[BTN_R];
      end
    end
  end

  assign xpos_out       = x_reg;
  assign ypos_out       = y_reg;
  assign mouseleft_out  = left_reg;
  assign mouseright_out = right_reg;
  assign pos_valid      = pos_valid_reg;
  assign sync_err       = sync_err_reg;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Scoreboard bench for mouse_packet_decoder: directed packets push expected
// positions, a negedge monitor pops and compares on each pos_valid pulse.
module tb_mouse_packet_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] xpos_out, ypos_out;
  logic        mouseleft_out, mouseright_out, pos_valid, sync_err;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        l;
    logic        r;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   sync_exp = 0;
  int   sync_seen = 0;

  mouse_packet_decoder #(
    .XMAX(800), .YMAX(600), .XINIT(400), .YINIT(300), .TIMEOUT_CYC(100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .xpos_out       (xpos_out),
    .ypos_out       (ypos_out),
    .mouseleft_out  (mouseleft_out),
    .mouseright_out (mouseright_out),
    .pos_valid      (pos_valid),
    .sync_err       (sync_err)
  );

  always #5 clk = ~clk;

  // Monitor: compares every pos_valid pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst && sync_err) sync_seen <= sync_seen + 1;
    if (rst && pos_valid) begin
      total <= total + 1;
      if (exp_q.size() == 0) begin
        bad <= bad + 1;
        $display("FAIL unexpected_pos_valid: got x=%0d y=%0d, required no update", xpos_out, ypos_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({xpos_out, ypos_out, mouseleft_out, mouseright_out} !== e) begin
          bad <= bad + 1;
          $display("FAIL update: got x=%0d y=%0d L=%0b R=%0b, required x=%0d y=%0d L=%0b R=%0b",
                   xpos_out, ypos_out, mouseleft_out, mouseright_out, e.x, e.y, e.l, e.r);
        end else begin
          $display("tx update x=%0d y=%0d L=%0b R=%0b ok", xpos_out, ypos_out, mouseleft_out, mouseright_out);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end else begin
      $display("tx %s = %0h ok", name, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                     input int ex, input int ey, input logic el, input logic er);
    exp_t e;
    e.x = 12'(ex); e.y = 12'(ey); e.l = el; e.r = er;
    exp_q.push_back(e);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    idle(3);
  endtask

  task automatic push_exp(input int ex, input int ey, input logic el, input logic er);
    exp_t e;
    e.x = 12'(ex); e.y = 12'(ey); e.l = el; e.r = er;
    exp_q.push_back(e);
  endtask

  task automatic end_test(input string name);
    idle(4);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_sync_errs"}, 32'(sync_seen), 32'(sync_exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {6'd0, xpos_out, ypos_out, mouseleft_out, mouseright_out, pos_valid, sync_err},
          {6'd0, 12'd400, 12'd300, 4'b0000});
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    pkt(8'h08, 8'h05, 8'h03, 405, 297, 1'b0, 1'b0);
    end_test("basic");

    do_reset();
    pkt(8'h19, 8'hFB, 8'h00, 395, 300, 1'b1, 1'b0);
    pkt(8'h0A, 8'h00, 8'h00, 395, 300, 1'b0, 1'b1);
    pkt(8'h0B, 8'h00, 8'h00, 395, 300, 1'b1, 1'b1);
    end_test("neg_dx_buttons");

    do_reset();
    pkt(8'h08, 8'h7F, 8'h00, 527, 300, 1'b0, 1'b0);
    pkt(8'h08, 8'h7F, 8'h00, 654, 300, 1'b0, 1'b0);
    pkt(8'h08, 8'h7F, 8'h00, 781, 300, 1'b0, 1'b0);
    pkt(8'h08, 8'h10, 8'h00, 797, 300, 1'b0, 1'b0);
    pkt(8'h08, 8'h0A, 8'h00, 799, 300, 1'b0, 1'b0);
    pkt(8'h08, 8'h00, 8'h7F, 799, 173, 1'b0, 1'b0);
    pkt(8'h08, 8'h00, 8'h7F, 799,  46, 1'b0, 1'b0);
    pkt(8'h08, 8'h00, 8'h2C, 799,   2, 1'b0, 1'b0);
    pkt(8'h08, 8'h00, 8'h05, 799,   0, 1'b0, 1'b0);
    pkt(8'h28, 8'h00, 8'h80, 799, 128, 1'b0, 1'b0);
    pkt(8'h28, 8'h00, 8'h01, 799, 383, 1'b0, 1'b0);
    pkt(8'h28, 8'h00, 8'h01, 799, 599, 1'b0, 1'b0);
    pkt(8'h18, 8'h01, 8'h00, 544, 599, 1'b0, 1'b0);
    pkt(8'h18, 8'h01, 8'h00, 289, 599, 1'b0, 1'b0);
    pkt(8'h18, 8'h01, 8'h00,  34, 599, 1'b0, 1'b0);
    pkt(8'h18, 8'h01, 8'h00,   0, 599, 1'b0, 1'b0);
    end_test("clamp");

    do_reset();
    pkt(8'h48, 8'hFF, 8'h02, 400, 298, 1'b0, 1'b0);
    pkt(8'h88, 8'h03, 8'h7F, 403, 298, 1'b0, 1'b0);
    end_test("overflow");

    do_reset();
    sync_exp++;
    send_byte(8'h05);
    idle(3);
    pkt(8'h08, 8'h01, 8'h00, 401, 300, 1'b0, 1'b0);
    end_test("sync");

    // Back-to-back bytes: a status byte and a bad byte land in UPDATE.
    do_reset();
    push_exp(401, 300, 1'b0, 1'b0);
    push_exp(403, 300, 1'b0, 1'b0);
    sync_exp++;
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h08); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h07);
    idle(3);
    end_test("stream");

    // Asynchronous reset mid-packet drops the partial packet immediately.
    do_reset();
    pkt(8'h08, 8'h01, 8'h00, 401, 300, 1'b0, 1'b0);
    send_byte(8'h08);
    send_byte(8'h05);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check("async_reset_pos", {8'd0, xpos_out, ypos_out}, {8'd0, 12'd400, 12'd300});
    @(negedge clk);
    rst = 1'b1;
    pkt(8'h08, 8'h01, 8'h00, 401, 300, 1'b0, 1'b0);
    end_test("midpkt_reset");

`ifdef MOUSE_PKT_TIMEOUT_EN
    do_reset();
    sync_exp++;
    send_byte(8'h08);
    send_byte(8'h03);
    idle(106);
    pkt(8'h08, 8'h01, 8'h00, 401, 300, 1'b0, 1'b0);
    end_test("timeout");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
